// File: rtl/pingpong_skew_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pingpong_skew_buffer
//  Description : Two-bank ping-pong tile buffer. A whole ROWS x DEPTH tile is
//                written in one beat. Each tile is drained one step per
//                accepted cycle, either diagonally skewed (systolic feed) or
//                row-aligned.
//                Tile element (r,k) sits at i_pre_data[(r*DEPTH+k)*WIDTH +: WIDTH].
//                Lane r sits at o_data[r*WIDTH +: WIDTH].
//  Revision    : 1.0 - initial release
// ============================================================================
module pingpong_skew_buffer #(
   parameter int ROWS    = 3,
   parameter int DEPTH   = 9,
   parameter int WIDTH   = 8,
   parameter int SKEW_EN = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rstn,
   input  logic                        i_flush,
   input  logic                        i_pre_valid,
   output logic                        o_pre_ready,
   input  logic [ROWS*DEPTH*WIDTH-1:0] i_pre_data,
   input  logic                        i_start,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [ROWS-1:0]             o_lane_valid,
   output logic [ROWS*WIDTH-1:0]       o_data,
   output logic                        o_last,
   output logic [1:0]                  o_full_cnt
);

   // Skewing stretches the drain by ROWS-1 steps so the last row can finish.
   localparam int c_steps  = (SKEW_EN != 0) ? (DEPTH + ROWS - 1) : DEPTH;
   localparam int c_tw     = $clog2(c_steps);
   localparam int c_kw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_tile_w = ROWS * DEPTH * WIDTH;
   localparam logic [c_tw-1:0] c_t_last = c_tw'(c_steps - 1);
   // DEPTH <= c_steps <= 2**c_tw, so one extra bit always holds DEPTH.
   localparam logic [c_tw:0]   c_depth  = (c_tw + 1)'(DEPTH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_tw-1:0]     r_t;
   logic [1:0]          r_full;
   logic [1:0]          w_full_nxt;
   logic                r_wbank;
   logic                r_rbank;
   logic [c_tile_w-1:0] r_bank0;
   logic [c_tile_w-1:0] r_bank1;
   logic [c_tile_w-1:0] w_rd_tile;
   logic                w_load;
   logic                w_start;
   logic                w_fire;
   logic                w_done;

   // Handshakes are derived from registered state only.
   assign o_pre_ready = ~r_full[r_wbank];
   assign w_load      = i_pre_valid & o_pre_ready;
   assign o_valid     = (r_state == RUN);
   assign w_fire      = o_valid & i_ready;
   assign o_last      = o_valid & (r_t == c_t_last);
   assign w_done      = w_fire & o_last;
   // A start only counts when seen in IDLE with a full bank; it is never queued.
   assign w_start     = (r_state == IDLE) & i_start & r_full[r_rbank];
   assign o_full_cnt  = {1'b0, r_full[0]} + {1'b0, r_full[1]};
   assign w_rd_tile   = r_rbank ? r_bank1 : r_bank0;

   // Next drain state; flush overrides everything else.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = RUN;
         RUN:     if (w_done)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (i_flush) w_state_nxt = IDLE;
   end

   // Drain state register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Load and drain-completion touch different banks, so both may apply at once.
   always_comb begin
      w_full_nxt = r_full;
      if (w_done) w_full_nxt[r_rbank] = 1'b0;
      if (w_load) w_full_nxt[r_wbank] = 1'b1;
   end

   // Bank flags, bank pointers and the drain step counter.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_full  <= 2'b00;
         r_wbank <= 1'b0;
         r_rbank <= 1'b0;
         r_t     <= '0;
      end else if (i_flush) begin
         r_full  <= 2'b00;
         r_wbank <= 1'b0;
         r_rbank <= 1'b0;
         r_t     <= '0;
      end else begin
         r_full <= w_full_nxt;
         if (w_load) r_wbank <= ~r_wbank;
         if (w_done) r_rbank <= ~r_rbank;
         if (w_start)     r_t <= '0;
         else if (w_done) r_t <= '0;
         else if (w_fire) r_t <= r_t + 1'b1;
      end
   end

   // Tile storage; contents need no reset because the flags gate every read.
   always_ff @(posedge i_clk) begin
      if (w_load && !i_flush) begin
         if (r_wbank) r_bank1 <= i_pre_data;
         else         r_bank0 <= i_pre_data;
      end
   end

   // Per-lane element select: lane r reads column t-r (skewed) or t (aligned).
   for (genvar g = 0; g < ROWS; g++) begin : g_lane
      localparam logic [c_tw:0] c_row = (c_tw + 1)'(g);
      logic [c_tw:0]   w_k;
      logic            w_in_range;
      logic [c_kw-1:0] w_idx;

      if (SKEW_EN != 0) begin : g_skew
         assign w_k        = {1'b0, r_t} - c_row;
         assign w_in_range = ({1'b0, r_t} >= c_row) && (w_k < c_depth);
      end else begin : g_align
         assign w_k        = {1'b0, r_t};
         assign w_in_range = (w_k < c_depth);
      end

      assign o_lane_valid[g] = o_valid & w_in_range;
      assign w_idx           = o_lane_valid[g] ? w_k[c_kw-1:0] : '0;
      assign o_data[g*WIDTH +: WIDTH] = o_lane_valid[g]
         ? w_rd_tile[(g*DEPTH + int'(w_idx))*WIDTH +: WIDTH]
         : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_pingpong_skew_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pingpong_skew_buffer
//  Description : Randomized self-checking bench. A skewed and an aligned
//                instance share stimulus. Each is compared every cycle with a
//                tile-FIFO reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_skew_buffer;

   localparam int ROWS   = 3;
   localparam int DEPTH  = 4;
   localparam int WIDTH  = 8;
   localparam int TILE_W = ROWS * DEPTH * WIDTH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rstn;
   logic              flush;
   logic              pre_valid;
   logic              start;
   logic              ready;
   logic [TILE_W-1:0] pre_data;

   logic                  pre_ready  [2];
   logic                  valid      [2];
   logic                  last       [2];
   logic [ROWS-1:0]       lane_valid [2];
   logic [ROWS*WIDTH-1:0] data       [2];
   logic [1:0]            full_cnt   [2];

   pingpong_skew_buffer #(.ROWS(ROWS), .DEPTH(DEPTH), .WIDTH(WIDTH), .SKEW_EN(1)) u_skew (
      .i_clk(clk), .i_rstn(rstn), .i_flush(flush),
      .i_pre_valid(pre_valid), .o_pre_ready(pre_ready[0]), .i_pre_data(pre_data),
      .i_start(start), .o_valid(valid[0]), .i_ready(ready),
      .o_lane_valid(lane_valid[0]), .o_data(data[0]), .o_last(last[0]),
      .o_full_cnt(full_cnt[0])
   );

   pingpong_skew_buffer #(.ROWS(ROWS), .DEPTH(DEPTH), .WIDTH(WIDTH), .SKEW_EN(0)) u_align (
      .i_clk(clk), .i_rstn(rstn), .i_flush(flush),
      .i_pre_valid(pre_valid), .o_pre_ready(pre_ready[1]), .i_pre_data(pre_data),
      .i_start(start), .o_valid(valid[1]), .i_ready(ready),
      .o_lane_valid(lane_valid[1]), .o_data(data[1]), .o_last(last[1]),
      .o_full_cnt(full_cnt[1])
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model per instance (0 = skewed, 1 = aligned):
   // an ordered list of undrained tiles (oldest first), plus a drain flag and step.
   logic [TILE_W-1:0] m_tile [2][2];
   int                m_n    [2];
   bit                m_run  [2];
   int                m_t    [2];

   function automatic int steps_of(input int m);
      return (m == 0) ? (DEPTH + ROWS - 1) : DEPTH;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset(input int m);
      m_n[m]   = 0;
      m_run[m] = 1'b0;
      m_t[m]   = 0;
   endtask

   // Advances the model by one rising edge using the inputs seen at that edge.
   task automatic model_update(input int m);
      bit can_load;
      bit fire;
      can_load = (m_n[m] < 2);
      fire     = m_run[m] && ready;
      if (!rstn || flush) begin
         model_reset(m);
      end else begin
         if (fire) begin
            if (m_t[m] == steps_of(m) - 1) begin
               m_tile[m][0] = m_tile[m][1];
               m_n[m]--;
               m_run[m] = 1'b0;
               m_t[m]   = 0;
            end else begin
               m_t[m]++;
            end
         end else if (!m_run[m] && start && m_n[m] > 0) begin
            m_run[m] = 1'b1;
            m_t[m]   = 0;
         end
         if (pre_valid && can_load) begin
            m_tile[m][m_n[m]] = pre_data;
            m_n[m]++;
         end
      end
   endtask

   task automatic check_all();
      logic [ROWS-1:0]       exp_lanes;
      logic [ROWS*WIDTH-1:0] exp_data;
      int                    k;
      string                 nm;
      for (int m = 0; m < 2; m++) begin
         nm        = (m == 0) ? "skew" : "align";
         exp_lanes = '0;
         exp_data  = '0;
         for (int r = 0; r < ROWS; r++) begin
            k = (m == 0) ? (m_t[m] - r) : m_t[m];
            if (m_run[m] && k >= 0 && k < DEPTH) begin
               exp_lanes[r] = 1'b1;
               exp_data[r*WIDTH +: WIDTH] = m_tile[m][0][(r*DEPTH + k)*WIDTH +: WIDTH];
            end
         end
         check_val({nm, ".pre_ready"}, 32'(pre_ready[m]), 32'(m_n[m] < 2));
         check_val({nm, ".valid"},     32'(valid[m]),     32'(m_run[m]));
         check_val({nm, ".last"},      32'(last[m]),      32'(m_run[m] && m_t[m] == steps_of(m) - 1));
         check_val({nm, ".full_cnt"},  32'(full_cnt[m]),  32'(m_n[m]));
         check_val({nm, ".lanes"},     32'(lane_valid[m]), 32'(exp_lanes));
         check_val({nm, ".data"},      32'(data[m]),      32'(exp_data));
      end
   endtask

   // Called just after a rising edge with inputs already set; returns just after the next edge.
   task automatic tick();
      if (!rstn) begin
         model_reset(0);
         model_reset(1);
      end
      #3;
      check_all();
      @(posedge clk);
      model_update(0);
      model_update(1);
      #1;
   endtask

   function automatic logic [TILE_W-1:0] rand_tile();
      logic [TILE_W-1:0] v;
      for (int i = 0; i < ROWS*DEPTH; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      return v;
   endfunction

   initial begin
      rstn      = 1'b0;
      flush     = 1'b0;
      pre_valid = 1'b0;
      start     = 1'b0;
      ready     = 1'b0;
      pre_data  = '0;
      model_reset(0);
      model_reset(1);
      @(posedge clk);
      #1;
      tick();
      tick();
      rstn = 1'b1;
      tick();

      // Known tile elem[r][k] = 16r+k, drained with the consumer always ready.
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < DEPTH; k++)
            pre_data[(r*DEPTH + k)*WIDTH +: WIDTH] = WIDTH'(16*r + k);
      pre_valid = 1'b1;
      tick();
      pre_valid = 1'b0;
      start     = 1'b1;
      ready     = 1'b1;
      tick();
      start = 1'b0;
      check_val("d.s0.lanes",  32'(lane_valid[0]), 32'h1);
      check_val("d.s0.lane0",  32'(data[0][7:0]),  32'h00);
      check_val("d.a0.data",   32'(data[1]),       32'h201000);
      tick();
      check_val("d.s1.lanes",  32'(lane_valid[0]), 32'h3);
      check_val("d.s1.data",   32'(data[0][15:0]), 32'h1001);
      tick();
      tick();
      check_val("d.s3.lanes",  32'(lane_valid[0]), 32'h7);
      check_val("d.s3.data",   32'(data[0]),       32'h211203);
      check_val("d.a3.last",   32'(last[1]),       32'h1);
      check_val("d.a3.data",   32'(data[1]),       32'h231303);
      tick();
      tick();
      check_val("d.s5.lanes",  32'(lane_valid[0]), 32'h4);
      check_val("d.s5.data",   32'(data[0]),       32'h230000);
      check_val("d.s5.last",   32'(last[0]),       32'h1);
      tick();
      check_val("d.end.cnt",   32'(full_cnt[0]),   32'h0);
      check_val("d.end.valid", 32'(valid[0]),      32'h0);

      // Two back-to-back loads fill both banks.
      pre_valid = 1'b1;
      pre_data  = rand_tile();
      tick();
      pre_data  = rand_tile();
      tick();
      pre_valid = 1'b0;
      check_val("d.two.ready", 32'(pre_ready[0]), 32'h0);
      check_val("d.two.cnt",   32'(full_cnt[0]),  32'h2);

      // Random traffic: stalls, loads during drain, ignored starts, flushes, async resets.
      for (int c = 0; c < 2000; c++) begin
         rstn      = ($urandom_range(0, 99) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         pre_valid = ($urandom_range(0, 1) == 1);
         start     = ($urandom_range(0, 3) == 0);
         ready     = ($urandom_range(0, 3) != 0);
         pre_data  = rand_tile();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
